// File: rtl/exu_muldiv_if.sv
// Issue/result bundle between the execute stage and the multi-cycle M-extension unit.
interface exu_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [4:0]      rd_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_o;

  modport master (
    output start_i, op_i, rs1_i, rs2_i, rd_i, flush_i,
    input  busy_o, done_o, result_o, rd_o
  );

  modport slave (
    input  start_i, op_i, rs1_i, rs2_i, rd_i, flush_i,
    output busy_o, done_o, result_o, rd_o
  );
endinterface

// File: rtl/exu_muldiv.sv
// Multi-cycle RISC-V M-extension unit: radix-2^MUL_BITS shift-add multiplier and
// 1-bit-per-cycle restoring divider sharing one IDLE/MUL/DIV/DONE controller.
module exu_muldiv #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 4
) (
  input logic          clk,
  input logic          rst,
  exu_muldiv_if.slave  bus
);
  localparam int NM = XLEN / MUL_BITS;
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rdl_q, rdl_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic              done_q, done_d;

  // Accept-time decode of the incoming request
  logic              is_div, div_signed, is_rem, a_signed, b_signed;
  logic              rs1_neg, rs2_neg, spec_zero, spec_ovf;
  logic [2*XLEN-1:0] a_ext, a_shift, acc_init;
  logic [XLEN-1:0]   a_mag, b_mag, spec_res;

  always_comb begin
    is_div     = bus.op_i[2];
    div_signed = ~bus.op_i[0];
    is_rem     = bus.op_i[1];
    a_signed   = ~bus.op_i[2] & (bus.op_i[1:0] != 2'b11);
    b_signed   = ~bus.op_i[2] & ~bus.op_i[1];
    rs1_neg    = bus.rs1_i[XLEN-1];
    rs2_neg    = bus.rs2_i[XLEN-1];
    a_ext      = {{XLEN{a_signed & rs1_neg}}, bus.rs1_i};
    a_shift    = {bus.rs1_i, {XLEN{1'b0}}};
    // Only the low XLEN multiplier bits are iterated; a negative signed rs2
    // contributes -rs1 * 2^XLEN, folded into the accumulator start value.
    acc_init   = (b_signed && rs2_neg) ? ({(2*XLEN){1'b0}} - a_shift) : '0;
    a_mag      = (div_signed && rs1_neg) ? -bus.rs1_i : bus.rs1_i;
    b_mag      = (div_signed && rs2_neg) ? -bus.rs2_i : bus.rs2_i;
    spec_zero  = (bus.rs2_i == '0);
    spec_ovf   = div_signed && (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_i == '1);
    if (spec_zero) spec_res = is_rem ? bus.rs1_i : '1;
    else           spec_res = is_rem ? '0 : bus.rs1_i;
  end

  // Multiplier datapath: MUL_BITS partial products per cycle
  logic [2*XLEN-1:0] pp [MUL_BITS];
  logic [2*XLEN-1:0] mul_sum;
  logic [XLEN-1:0]   mul_res;

  for (genvar gi = 0; gi < MUL_BITS; gi++) begin : g_pp
    assign pp[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
  end

  always_comb begin
    mul_sum = acc_q;
    for (int i = 0; i < MUL_BITS; i++) mul_sum = mul_sum + pp[i];
    mul_res = (op_q[1:0] == 2'b00) ? mul_sum[XLEN-1:0] : mul_sum[2*XLEN-1:XLEN];
  end

  // Divider datapath: one restoring step per cycle on magnitudes
  logic [XLEN:0]   rem_sh, diff;
  logic            take;
  logic [XLEN-1:0] rem_step, quo_step, div_res;

  always_comb begin
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    diff     = rem_sh - {1'b0, dvsr_q};
    take     = ~diff[XLEN];
    rem_step = take ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_step = {quo_q[XLEN-2:0], take};
    if (op_q[1]) div_res = r_neg_q ? -rem_step : rem_step;
    else         div_res = q_neg_q ? -quo_step : quo_step;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rdl_d    = rdl_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    res_d    = res_q;
    rd_out_d = rd_out_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start_i && !bus.flush_i) begin
          op_d  = bus.op_i;
          rdl_d = bus.rd_i;
          cnt_d = '0;
          if (!is_div) begin
            mcand_d  = a_ext;
            mplier_d = bus.rs2_i;
            acc_d    = acc_init;
            state_d  = S_MUL;
          end else if (spec_zero || spec_ovf) begin
            res_d    = spec_res;
            rd_out_d = bus.rd_i;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            quo_d   = a_mag;
            rem_d   = '0;
            dvsr_d  = b_mag;
            q_neg_d = div_signed & (rs1_neg ^ rs2_neg);
            r_neg_d = div_signed & rs1_neg;
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d    = mul_sum;
          mcand_d  = mcand_q << MUL_BITS;
          mplier_d = mplier_q >> MUL_BITS;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(NM - 1)) begin
            res_d    = mul_res;
            rd_out_d = rdl_q;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_DIV: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) begin
            res_d    = div_res;
            rd_out_d = rdl_q;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rdl_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      res_q    <= '0;
      rd_out_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rdl_q    <= rdl_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      res_q    <= res_d;
      rd_out_q <= rd_out_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy_o   = (state_q == S_MUL) || (state_q == S_DIV);
  assign bus.done_o   = done_q;
  assign bus.result_o = res_q;
  assign bus.rd_o     = rd_out_q;
endmodule

// File: tb/tb_exu_muldiv.sv
// Scoreboard bench for exu_muldiv: stimulus pushes expected results, a monitor
// thread pops and compares on every done_o pulse (value, rd and arrival cycle).
module tb_exu_muldiv;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exu_muldiv_if #(.XLEN(XLEN)) bus();
  exu_muldiv #(.XLEN(XLEN), .MUL_BITS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
    string       name;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at posedge+1; the cycle in which start_i is high is cycle 0.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input string name, input logic [31:0] exp,
                       input int lat, input bit expect_done);
    exp_t e;
    bus.op_i    = op;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    bus.rd_i    = rd;
    bus.start_i = 1'b1;
    if (expect_done) begin
      e.res = exp; e.rd = rd; e.cyc = cyc + lat; e.name = name;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (sb.size() == 0 && !bus.busy_o) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i    = '0;
    bus.rs1_i   = '0;
    bus.rs2_i   = '0;
    bus.rd_i    = '0;
    bus.flush_i = 1'b0;

    fork
      begin : monitor
        exp_t m;
        forever begin
          @(posedge clk); #1;
          if (bus.done_o) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done: got done_o=1 rd=%0d result=0x%08h expected no done_o",
                       bus.rd_o, bus.result_o);
            end else begin
              m = sb.pop_front();
              chk({m.name, "_result"}, bus.result_o, m.res);
              chk({m.name, "_rd"}, {27'b0, bus.rd_o}, {27'b0, m.rd});
              chk({m.name, "_cycle"}, cyc, m.cyc);
              last_res = m.res;
              $display("txn %s rd=%0d result=0x%08h cycle=%0d", m.name, bus.rd_o, bus.result_o, cyc);
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'b0, bus.busy_o}, 32'd0);
    chk("reset_done", {31'b0, bus.done_o}, 32'd0);
    chk("reset_result", bus.result_o, 32'd0);
    chk("reset_rd", {27'b0, bus.rd_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // MUL with busy profile over cycles 1..8
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, "mul_7x-3", 32'hFFFF_FFEB, 9, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("mul_busy_c%0d", i), {31'b0, bus.busy_o}, 32'd1);
      if (i < 8) begin @(posedge clk); #1; end
    end
    drain();

    vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 9, "mulh_min_min"});
    vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 9, "mulhu_max_max"});
    vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 9, "mulhsu_m1_max"});
    vecs.push_back('{3'b000, 32'h1234_5678, 32'h0000_0010, 5'd4, 32'h2345_6780, 9, "mul_shift4"});
    vecs.push_back('{3'b011, 32'h8000_0000, 32'h0000_0002, 5'd6, 32'h0000_0001, 9, "mulhu_carry"});
    vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 33, "div_-7_2"});
    vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 33, "rem_-7_2"});
    vecs.push_back('{3'b101, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'h7FFF_FFFC, 33, "divu_big_2"});
    vecs.push_back('{3'b100, 32'd100, 32'hFFFF_FFF9, 5'd0, 32'hFFFF_FFF2, 33, "div_100_-7_rd0"});
    vecs.push_back('{3'b110, 32'd100, 32'hFFFF_FFF9, 5'd10, 32'd2, 33, "rem_100_-7"});
    vecs.push_back('{3'b111, 32'd100, 32'd7, 5'd11, 32'd2, 33, "remu_100_7"});
    vecs.push_back('{3'b100, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 1, "div_by_zero"});
    vecs.push_back('{3'b111, 32'd5, 32'd0, 5'd13, 32'd5, 1, "remu_by_zero"});
    vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1, "div_overflow"});
    vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 1, "rem_overflow"});

    foreach (vecs[k]) begin
      issue(vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].rd, vecs[k].name, vecs[k].exp, vecs[k].lat, 1'b1);
      if (vecs[k].lat == 1) chk({vecs[k].name, "_busy"}, {31'b0, bus.busy_o}, 32'd0);
      drain();
    end

    // start_i held high while busy must not queue a second operation
    issue(3'b000, 32'd6, 32'd7, 5'd16, "mul_hold_start", 32'd42, 9, 1'b1);
    bus.op_i = 3'b100; bus.rs1_i = 32'd100; bus.rs2_i = 32'd3; bus.start_i = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    bus.start_i = 1'b0;
    chk("hold_busy_c6", {31'b0, bus.busy_o}, 32'd1);
    drain();

    // Back-to-back: MUL issued in the DONE cycle of a DIVU
    issue(3'b101, 32'd100, 32'd7, 5'd17, "divu_b2b", 32'd14, 33, 1'b1);
    repeat (32) begin @(posedge clk); #1; end
    issue(3'b000, 32'd3, 32'd5, 5'd18, "mul_b2b", 32'd15, 9, 1'b1);
    drain();

    // flush at cycle 10 of a DIV
    issue(3'b100, 32'd1000, 32'd10, 5'd19, "div_flushed", 32'd100, 33, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    chk("flush_busy", {31'b0, bus.busy_o}, 32'd0);
    chk("flush_done", {31'b0, bus.done_o}, 32'd0);
    chk("flush_result_kept", bus.result_o, last_res);
    repeat (40) @(posedge clk);
    #1;

    // start together with flush in IDLE is dropped
    bus.flush_i = 1'b1;
    issue(3'b000, 32'd9, 32'd9, 5'd20, "mul_start_flush", 32'd81, 9, 1'b0);
    bus.flush_i = 1'b0;
    chk("start_flush_busy", {31'b0, bus.busy_o}, 32'd0);
    repeat (12) @(posedge clk);
    #1;

    // reset at cycle 4 of a MUL
    issue(3'b000, 32'h1234, 32'h5678, 5'd21, "mul_reset", 32'd0, 9, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_busy", {31'b0, bus.busy_o}, 32'd0);
    chk("rst_mid_done", {31'b0, bus.done_o}, 32'd0);
    chk("rst_mid_result", bus.result_o, 32'd0);
    chk("rst_mid_rd", {27'b0, bus.rd_o}, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    issue(3'b000, 32'd3, 32'd4, 5'd22, "mul_after_rst", 32'd12, 9, 1'b1);
    drain();
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exu_muldiv.md
Name: exu_muldiv

Overview:
- Parametrised, multi-cycle RISC-V M-extension unit that replaces the single-cycle `*`, `/` and `%` paths in the execute stage.
- Implements all eight M operations with correct signed, unsigned and mixed semantics, including the architected divide-by-zero and overflow results.
- Sits beside the execute ALU. While an operation is in flight, `busy_o` drives the pipeline hold; on `done_o` the result and destination register go to the register write port.

Parameters:
- XLEN, 32, operand and result width (must be even).
- MUL_BITS, 4, multiplier bits retired per cycle; must divide XLEN. MUL iteration count NM = XLEN/MUL_BITS.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start_i  in  1  request; accepted only when busy_o=0.
- op_i  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_i  in  XLEN  operand x[rs1]; sampled on accept.
- rs2_i  in  XLEN  operand x[rs2]; sampled on accept.
- rd_i  in  5  destination register; sampled on accept.
- flush_i  in  1  abort the in-flight operation (jump or flush).
- busy_o  out  1  operation in flight; used as pipeline hold.
- done_o  out  1  one-cycle result-valid pulse.
- result_o  out  XLEN  result; held until the next done_o.
- rd_o  out  5  destination of result_o; held with result_o.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, internal registers cleared. Reset wins over every other input in the same cycle, including mid-operation; no done_o is produced for the aborted operation.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE + start_i, MUL op: latch operands, go to MUL.
  - IDLE + start_i, DIV/REM op, normal case: go to DIV.
  - IDLE + start_i, DIV/REM op, special case (below): go directly to DONE.
  - MUL: counter counts NM cycles, then DONE.
  - DIV: counter counts XLEN cycles, then DONE.
  - DONE: exactly one cycle. done_o=1 and result_o/rd_o update in this cycle; next state is IDLE, or accept a new start_i (see next item).
- busy_o = 1 in MUL and DIV; 0 in IDLE and DONE. start_i in DONE is accepted (back-to-back issue). start_i while busy_o=1 is ignored.
- Latency, with accept at cycle 0:
  - MUL ops: done_o at cycle NM+1 (9 for the defaults).
  - Normal DIV/REM: done_o at cycle XLEN+1 (33).
  - Special DIV/REM: done_o at cycle 1.
- Multiply:
  - Operands are extended to 2*XLEN: signed for MUL, MULH and rs1 of MULHSU; unsigned otherwise.
  - Iterative shift-add over MUL_BITS bits per cycle.
  - MUL returns product[XLEN-1:0]; MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN].
- Divide:
  - Restoring, 1 bit per cycle, on magnitudes.
  - Signed ops take absolute values. Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1). Signs are applied in the DONE cycle.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases, decided at accept:
  - rs2=0: quotient = all ones; remainder = rs1 (signed and unsigned).
  - DIV/REM with rs1 = most-negative value and rs2 = -1: quotient = rs1, remainder = 0.
- flush_i:
  - In MUL or DIV: next state IDLE, busy_o=0 next cycle, no done_o, result_o/rd_o keep their old values.
  - flush_i together with start_i in IDLE or DONE: start is dropped.
  - flush_i in DONE: done_o still pulses (the result is already committed).
- rd_i=0 is computed normally; write suppression belongs to the register file.
- result_o and rd_o change only in the DONE cycle.

Test Plan:
- MUL, rs1=7, rs2=0xFFFFFFFD (-3), rd=5 -> busy_o high for cycles 1-8; done_o at cycle 9 with result_o=0xFFFFFFEB, rd_o=5.
- High-half multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed and unsigned divide, 0xFFFFFFF9 (-7) by 2:
  - DIV -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; both with done_o at cycle 33.
  - DIVU -> 0x7FFFFFFC.
- Special cases, each with done_o at cycle 1 and busy_o never high:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5%0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Control:
  - start_i held high during busy -> ignored.
  - Back-to-back: MUL accepted in the DONE cycle of a DIV -> its done_o is NM+1 cycles later.
  - flush_i at cycle 10 of a DIV -> busy_o=0 at cycle 11, no done_o, result_o unchanged.
- rst asserted at cycle 4 of a MUL -> all outputs 0 next cycle, no done_o. A new MUL 3x4 issued afterwards -> 12 at latency 9.
